// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// display_scan_mux : registered N-channel digit scanner with prescaler-driven
//                    auto scan, manual override, blanking and dead cycle.
// Revision 1.0
// ============================================================================
module display_scan_mux #(
  parameter int W   = 4,
  parameter int CH  = 4,
  parameter int DIV = 1000,
  parameter int SW  = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] din,
  input  logic            auto_en,
  input  logic [SW-1:0]   man_sel,
  input  logic [CH-1:0]   blank,
  output logic [W-1:0]    y,
  output logic [CH-1:0]   en,
  output logic [SW-1:0]   sel_o
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(CH - 1);
  localparam logic [CH-1:0] ONE_HOT0 = CH'(1);

  logic [CW-1:0] cnt;
  logic [SW-1:0] idx;
  logic          dead;

  logic [CW-1:0] cnt_next;
  logic [SW-1:0] idx_next;
  logic          dead_next;
  logic [SW-1:0] target;
  logic [W-1:0]  digit [CH];

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_unpack
      assign digit[k] = din[k*W +: W];
    end
  endgenerate

  // Out-of-range selects (non-power-of-two CH) land on the last channel.
  always_comb begin
    target = man_sel;
    if ({{(32-SW){1'b0}}, man_sel} >= 32'(CH)) begin
      target = IDX_LAST;
    end
  end

  always_comb begin
    cnt_next  = cnt;
    idx_next  = idx;
    dead_next = 1'b0;
    if (auto_en) begin
      if (cnt == CNT_LAST) begin
        cnt_next  = '0;
        idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        dead_next = 1'b1;
      end else begin
        cnt_next  = cnt + 1'b1;
      end
    end else begin
      cnt_next = '0;
      if (target != idx) begin
        idx_next  = target;
        dead_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      dead <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      idx  <= idx_next;
      dead <= dead_next;
    end
  end

  // Outputs are taken from the pre-edge state, so a channel change shows on
  // y one edge later and its enable one edge after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      en    <= '0;
      sel_o <= '0;
    end else begin
      y     <= digit[idx];
      sel_o <= idx;
      en    <= (dead | blank[idx]) ? '0 : (ONE_HOT0 << idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// Directed self-checking bench for display_scan_mux (three parameter sets).
module tb_display_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Set A: CH=4, DIV=4
  logic        rst_a, auto_a;
  logic [15:0] din_a;
  logic [1:0]  man_a;
  logic [3:0]  blank_a;
  logic [3:0]  y_a;
  logic [3:0]  en_a;
  logic [1:0]  sel_a;

  // Set B: CH=6, DIV=4
  logic        rst_b, auto_b;
  logic [23:0] din_b;
  logic [2:0]  man_b;
  logic [5:0]  blank_b;
  logic [3:0]  y_b;
  logic [5:0]  en_b;
  logic [2:0]  sel_b;

  // Set C: CH=3, DIV=2
  logic        rst_c, auto_c;
  logic [11:0] din_c;
  logic [1:0]  man_c;
  logic [2:0]  blank_c;
  logic [3:0]  y_c;
  logic [2:0]  en_c;
  logic [1:0]  sel_c;

  int errors = 0;
  int checks = 0;

  display_scan_mux #(.W(4), .CH(4), .DIV(4)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .auto_en(auto_a), .man_sel(man_a),
    .blank(blank_a), .y(y_a), .en(en_a), .sel_o(sel_a));

  display_scan_mux #(.W(4), .CH(6), .DIV(4)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .auto_en(auto_b), .man_sel(man_b),
    .blank(blank_b), .y(y_b), .en(en_b), .sel_o(sel_b));

  display_scan_mux #(.W(4), .CH(3), .DIV(2)) dut_c (
    .clk(clk), .rst(rst_c), .din(din_c), .auto_en(auto_c), .man_sel(man_c),
    .blank(blank_c), .y(y_c), .en(en_c), .sel_o(sel_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int ey, input int een, input int esel);
    chk({tag, ".y"},   32'(y_a),   32'(ey));
    chk({tag, ".en"},  32'(en_a),  32'(een));
    chk({tag, ".sel"}, 32'(sel_a), 32'(esel));
  endtask

  // One clock edge, then the every-cycle never-multi-hot checks.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot_a", 32'($onehot0(en_a)), 32'd1);
    chk("onehot_b", 32'($onehot0(en_b)), 32'd1);
    chk("onehot_c", 32'($onehot0(en_c)), 32'd1);
  endtask

  initial begin
    int ch, pos, ey, een, y0;

    rst_a = 1'b1; auto_a = 1'b1; din_a = 16'h4321; man_a = 2'd0; blank_a = 4'b0000;
    rst_b = 1'b1; auto_b = 1'b0; din_b = 24'h654321; man_b = 3'd0; blank_b = 6'b0;
    rst_c = 1'b1; auto_c = 1'b1; din_c = 12'h321; man_c = 2'd0; blank_c = 3'b000;

    tick();
    chk_a("reset", 0, 0, 0);
    rst_a = 1'b0;

    // Test 1: auto scan including wrap 3 -> 0
    for (int e = 1; e <= 20; e++) begin
      tick();
      ch  = ((e - 1) / 4) % 4;
      pos = (e - 1) % 4;
      een = (pos == 0) ? 0 : (1 << ch);
      chk_a($sformatf("t1_e%0d", e), ch + 1, een, ch);
    end

    // Test 2: channel 2 blanked
    blank_a = 4'b0100;
    for (int e = 21; e <= 36; e++) begin
      tick();
      ch  = ((e - 1) / 4) % 4;
      pos = (e - 1) % 4;
      een = (pos == 0 || ch == 2) ? 0 : (1 << ch);
      chk_a($sformatf("t2_e%0d", e), ch + 1, een, ch);
    end
    blank_a = 4'b0000;

    // Test 3: manual select from idx 0
    rst_a = 1'b1;
    tick();
    chk_a("t3_rst", 0, 0, 0);
    rst_a = 1'b0; auto_a = 1'b0; man_a = 2'd2;
    tick(); chk_a("t3_p1", 1, 0, 0);
    tick(); chk_a("t3_p2", 3, 0, 2);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_a($sformatf("t3_hold%0d", i), 3, 4'b0100, 2);
    end

    // Test 3b: CH=6 clamp of out-of-range select
    rst_b = 1'b0; man_b = 3'd7;
    tick(); chk("t3b_p1.en", 32'(en_b), 32'd0);
    tick();
    chk("t3b_p2.y",   32'(y_b),   32'd6);
    chk("t3b_p2.sel", 32'(sel_b), 32'd5);
    chk("t3b_p2.en",  32'(en_b),  32'd0);
    man_b = 3'd5;
    tick(); chk("t3b_p3.en", 32'(en_b), 32'h20);
    man_b = 3'd6;
    tick(); chk("t3b_p4.en", 32'(en_b), 32'h20);
    tick();
    chk("t3b_p5.en", 32'(en_b), 32'h20);
    chk("t3b_p5.y",  32'(y_b),  32'd6);

    // Test 4a: manual channel 1, then switch to auto
    man_a = 2'd1;
    tick(); chk_a("t4_m1", 3, 4'b0100, 2);
    tick(); chk_a("t4_m2", 2, 0, 1);
    tick(); chk_a("t4_m3", 2, 4'b0010, 1);
    auto_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk_a($sformatf("t4_s%0d", i), 2, 4'b0010, 1);
    end
    tick(); chk_a("t4_s5", 3, 0, 2);
    tick(); chk_a("t4_s6", 3, 4'b0100, 2);

    // Test 4b: auto mid-count to manual on the same channel
    auto_a = 1'b0; man_a = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk_a($sformatf("t4b_%0d", i), 3, 4'b0100, 2);
    end

    // Test 5: reset while en = 0100, restart, then din tracking on channel 0
    rst_a = 1'b1; auto_a = 1'b1;
    tick(); chk_a("t5_rst", 0, 0, 0);
    rst_a = 1'b0;
    y0 = 1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      ch  = ((e - 1) / 4) % 4;
      pos = (e - 1) % 4;
      een = (pos == 0) ? 0 : (1 << ch);
      ey  = (ch == 0) ? y0 : ch + 1;
      chk_a($sformatf("t5_e%0d", e), ey, een, ch);
      if (e == 2) begin
        din_a = 16'h4329;
        y0 = 9;
      end
    end
    din_a = 16'h4321;

    // Test 6: CH=3, DIV=2 sweep with wrap 2 -> 0
    rst_c = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      ch  = ((e - 1) / 2) % 3;
      pos = (e - 1) % 2;
      een = (pos == 0) ? 0 : (1 << ch);
      chk($sformatf("t6_e%0d.y", e),   32'(y_c),   32'(ch + 1));
      chk($sformatf("t6_e%0d.en", e),  32'(en_c),  32'(een));
      chk($sformatf("t6_e%0d.sel", e), 32'(sel_c), 32'(ch));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
